// File: rtl/alu_pkg.sv
// Shared ALU/R-type encodings and controller state type for the multicycle
// R-type issue path.
package alu_pkg;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;
  localparam logic [1:0] ALU_SLT = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] F_AND    = 6'h24;
  localparam logic [5:0] F_OR     = 6'h25;
  localparam logic [5:0] F_ADD    = 6'h20;
  localparam logic [5:0] F_SLT    = 6'h2A;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    EXEC,
    WB
  } state_e;

endpackage

// File: rtl/rtype_decode.sv
// Combinational R-type decoder: maps op/funct to an ALU select and flags
// anything outside the four supported functions as illegal.
module rtype_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output logic [1:0]  alu_s,
  output logic        legal,
  output logic [4:0]  rd
);

  // Register addresses and shamt are not part of the legality decision.
  logic unused_fields;
  assign unused_fields = ^{instr[25:16], instr[10:6]};

  always_comb begin
    alu_s = ALU_AND;
    legal = 1'b0;
    rd    = instr[15:11];
    if (instr[31:26] == OP_RTYPE) begin
      case (instr[5:0])
        F_AND: begin alu_s = ALU_AND; legal = 1'b1; end
        F_OR:  begin alu_s = ALU_OR;  legal = 1'b1; end
        F_ADD: begin alu_s = ALU_ADD; legal = 1'b1; end
        F_SLT: begin alu_s = ALU_SLT; legal = 1'b1; end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rtype_exec_ctrl.sv
// Multicycle R-type issue controller: accepts an instruction, reads operands,
// drives the ALU for one operation and writes the result back.
module rtype_exec_ctrl
  import alu_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  output logic              instr_ready,
  output logic [REG_AW-1:0] rs_addr,
  output logic [REG_AW-1:0] rt_addr,
  input  logic [31:0]       rs_data,
  input  logic [31:0]       rt_data,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  output logic [1:0]        alu_s,
  input  logic [31:0]       alu_out,
  input  logic              alu_zf,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [31:0]       rf_wdata,
  output logic              zero_flag,
  output logic              illegal,
  output logic [CNT_W-1:0]  retired
);

  state_e              state_q, state_d;
  logic [31:0]         instr_q, instr_d;
  logic [31:0]         alu_a_q, alu_a_d;
  logic [31:0]         alu_b_q, alu_b_d;
  logic [1:0]          alu_s_q, alu_s_d;
  logic [31:0]         result_q, result_d;
  logic                zf_q, zf_d;
  logic                rf_we_q, rf_we_d;
  logic [REG_AW-1:0]   rf_waddr_q, rf_waddr_d;
  logic [CNT_W-1:0]    retired_q, retired_d;

  logic [1:0]          dec_s;
  logic                dec_legal;
  logic [4:0]          dec_rd;

  rtype_decode u_decode (
    .instr (instr_q),
    .alu_s (dec_s),
    .legal (dec_legal),
    .rd    (dec_rd)
  );

  // The write strobe is registered out of WB so it lands in the cycle after
  // the fourth edge, overlapping the next IDLE.
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_s_d     = alu_s_q;
    result_d    = result_q;
    zf_d        = zf_q;
    rf_we_d     = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    retired_d   = retired_q;
    instr_ready = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          instr_d = instr;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (!dec_legal) begin
          illegal = 1'b1;
          state_d = IDLE;
        end else begin
          alu_a_d = rs_data;
          alu_b_d = rt_data;
          alu_s_d = dec_s;
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_out;
        zf_d     = alu_zf;
        state_d  = WB;
      end
      WB: begin
        rf_we_d    = (dec_rd != 5'd0);
        rf_waddr_d = REG_AW'(dec_rd);
        retired_d  = retired_q + CNT_W'(1);
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      instr_q    <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_s_q    <= '0;
      result_q   <= '0;
      zf_q       <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_s_q    <= alu_s_d;
      result_q   <= result_d;
      zf_q       <= zf_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      retired_q  <= retired_d;
    end
  end

  assign rs_addr   = REG_AW'(instr_q[25:21]);
  assign rt_addr   = REG_AW'(instr_q[20:16]);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_s     = alu_s_q;
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = result_q;
  assign zero_flag = zf_q;
  assign retired   = retired_q;

endmodule
